// File: rtl/fifo_mem_pkg.sv
// Shared types and helpers for the byte-enable FIFO storage array.
package fifo_mem_pkg;

    // Widest data path the lane-merge helper supports.
    localparam int unsigned MERGE_W   = 1024;
    localparam int unsigned MERGE_NBE = MERGE_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

    function automatic int unsigned calc_nbe(input int unsigned dw);
        return dw / 8;
    endfunction

    // Per-lane select: enabled lanes take new_d, the rest keep old_d.
    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0]   old_d,
        input logic [MERGE_W-1:0]   new_d,
        input logic [MERGE_NBE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_d;
        for (int i = 0; i < int'(MERGE_NBE); i++) begin
            if (be[i]) res[i*8 +: 8] = new_d[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_mem_be_if.sv
// Write/read/clear port bundle of the FIFO storage array.
interface fifo_mem_be_if
    import fifo_mem_pkg::*;
#(
    parameter int unsigned dw = 16,
    parameter int unsigned aw = 8
);
    localparam int unsigned nbe = calc_nbe(dw);

    logic           init_req;
    logic           init_busy;
    logic           wclken;
    logic [nbe-1:0] wbe;
    logic [aw-1:0]  waddr;
    logic [dw-1:0]  wdata;
    logic           rclken;
    logic [aw-1:0]  raddr;
    logic [dw-1:0]  rdata;
    logic           rvalid;

    modport master (
        output init_req, wclken, wbe, waddr, wdata, rclken, raddr,
        input  init_busy, rdata, rvalid
    );

    modport slave (
        input  init_req, wclken, wbe, waddr, wdata, rclken, raddr,
        output init_busy, rdata, rvalid
    );

endinterface

// File: rtl/fifo_mem_clr.sv
// Sequential clear engine: sweeps every address once after reset or on request.
module fifo_mem_clr
    import fifo_mem_pkg::*;
#(
    parameter int unsigned aw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_req,
    output logic          init_busy,
    output logic          clr_we,
    output logic [aw-1:0] clr_addr
);
    localparam logic [aw-1:0] cnt_last = {aw{1'b1}};

    clr_state_t    state, state_nxt;
    logic [aw-1:0] cnt, cnt_nxt;
    logic          busy;

    // State, sweep counter and busy flag; busy mirrors the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == CLEAR);
        end
    end

    // Terminal compare ends the sweep; requests during a sweep are ignored.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            CLEAR: begin
                if (cnt == cnt_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + aw'(1);
                end
            end
            IDLE: begin
                if (init_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign init_busy = busy;
    assign clr_we    = busy;
    assign clr_addr  = cnt;

endmodule

// File: rtl/fifo_mem_be.sv
// Dual-port FIFO storage with byte-lane writes, 0/1-cycle read and clear engine.
module fifo_mem_be
    import fifo_mem_pkg::*;
#(
    parameter int unsigned dw     = 16,
    parameter int unsigned aw     = 8,
    parameter int unsigned rd_lat = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_mem_be_if.slave  bus
);
    localparam int unsigned nbe   = calc_nbe(dw);
    localparam int unsigned depth = 1 << aw;

    logic [dw-1:0] mem [depth];
    logic          busy;
    logic          clr_we;
    logic [aw-1:0] clr_addr;
    logic [dw-1:0] wr_merge_c;

    fifo_mem_clr #(.aw(aw)) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (bus.init_req),
        .init_busy (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign bus.init_busy = busy;

    assign wr_merge_c = dw'(lane_merge(MERGE_W'(mem[bus.waddr]), MERGE_W'(bus.wdata),
                                       MERGE_NBE'(bus.wbe)));

    // Clear sweep owns the write port; user writes only land when idle.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (bus.wclken) begin
            mem[bus.waddr] <= wr_merge_c;
        end
    end

    generate
        if (rd_lat == 0) begin : g_rd_comb
            // Read-old: a same-cycle write only shows up after the edge.
            assign bus.rdata  = mem[bus.raddr];
            assign bus.rvalid = bus.rclken & ~busy;
        end else begin : g_rd_reg
            logic [dw-1:0] rd_merge_c;
            logic [dw-1:0] rdata_q;
            logic          rvalid_q;
            logic          hit_c;

            // Write-first bypass for a same-address write in the read cycle.
            assign hit_c      = bus.wclken && (bus.waddr == bus.raddr);
            assign rd_merge_c = hit_c
                ? dw'(lane_merge(MERGE_W'(mem[bus.raddr]), MERGE_W'(bus.wdata),
                                 MERGE_NBE'(bus.wbe)))
                : mem[bus.raddr];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= bus.rclken & ~busy;
                    if (bus.rclken && !busy) rdata_q <= rd_merge_c;
                end
            end

            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end
    endgenerate

    // nbe is kept for readability of the lane geometry alongside the bus.
    logic unused_ok;
    assign unused_ok = (nbe == 0);

endmodule

// File: tb/tb_fifo_mem_be.sv
// Directed bench: registered-read instance plus a combinational-read instance.
module tb_fifo_mem_be;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fifo_mem_be_if #(.dw(16), .aw(8)) bus1 ();
    fifo_mem_be_if #(.dw(16), .aw(8)) bus0 ();

    fifo_mem_be #(.dw(16), .aw(8), .rd_lat(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    fifo_mem_be #(.dw(16), .aw(8), .rd_lat(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle1();
        bus1.init_req = 1'b0;
        bus1.wclken   = 1'b0;
        bus1.wbe      = 2'b00;
        bus1.waddr    = '0;
        bus1.wdata    = '0;
        bus1.rclken   = 1'b0;
        bus1.raddr    = '0;
    endtask

    task automatic wr1(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        bus1.wclken = 1'b1;
        bus1.waddr  = a;
        bus1.wdata  = d;
        bus1.wbe    = be;
        @(posedge clk); #1;
        bus1.wclken = 1'b0;
    endtask

    task automatic rd1(input logic [7:0] a, output logic [15:0] d, output logic v);
        bus1.rclken = 1'b1;
        bus1.raddr  = a;
        @(posedge clk); #1;
        d = bus1.rdata;
        v = bus1.rvalid;
        bus1.rclken = 1'b0;
    endtask

    // Edges counted until init_busy falls; bounded so a stuck engine cannot hang.
    task automatic wait_idle1(output int n);
        n = 0;
        while (bus1.init_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        v;
        int          n;
        int          bad;
        int          rv_seen;

        vecs[0]  = '{0, 8'd0,   16'h0000, 2'b00, 16'h0000};
        vecs[1]  = '{0, 8'd1,   16'h0000, 2'b00, 16'h0000};
        vecs[2]  = '{0, 8'd128, 16'h0000, 2'b00, 16'h0000};
        vecs[3]  = '{0, 8'd255, 16'h0000, 2'b00, 16'h0000};
        vecs[4]  = '{1, 8'd5,   16'hABCD, 2'b11, 16'h0000};
        vecs[5]  = '{1, 8'd5,   16'h1234, 2'b01, 16'h0000};
        vecs[6]  = '{0, 8'd5,   16'h0000, 2'b00, 16'hAB34};
        vecs[7]  = '{1, 8'd5,   16'hFFFF, 2'b00, 16'h0000};
        vecs[8]  = '{0, 8'd5,   16'h0000, 2'b00, 16'hAB34};
        vecs[9]  = '{1, 8'd255, 16'hBEEF, 2'b10, 16'h0000};
        vecs[10] = '{0, 8'd255, 16'h0000, 2'b00, 16'hBE00};
        vecs[11] = '{1, 8'd0,   16'hCAFE, 2'b01, 16'h0000};
        vecs[12] = '{0, 8'd0,   16'h0000, 2'b00, 16'h00FE};

        rst_n = 1'b0;
        idle1();
        bus0.init_req = 1'b0;
        bus0.wclken   = 1'b0;
        bus0.wbe      = 2'b00;
        bus0.waddr    = '0;
        bus0.wdata    = '0;
        bus0.rclken   = 1'b0;
        bus0.raddr    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus1.init_busy), 32'd1);
        check("rst_rvalid", 32'(bus1.rvalid), 32'd0);
        check("rst_rdata", 32'(bus1.rdata), 32'h0);

        @(negedge clk) rst_n = 1'b1;
        wait_idle1(n);
        check("rst_busy_len", 32'(n), 32'd256);
        check("rst_busy0_done", 32'(bus0.init_busy), 32'd0);

        // Table of writes and reads on the registered-read instance.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                wr1(vecs[i].addr, vecs[i].data, vecs[i].be);
            end else begin
                rd1(vecs[i].addr, d, v);
                check($sformatf("vec%0d_rvalid", i), 32'(v), 32'd1);
                check($sformatf("vec%0d_rdata", i), 32'(d), 32'(vecs[i].exp));
            end
        end

        @(posedge clk); #1;
        check("hold_rvalid", 32'(bus1.rvalid), 32'd0);
        check("hold_rdata", 32'(bus1.rdata), 32'h00FE);

        // Write-first bypass with a partial lane enable.
        wr1(8'd9, 16'h1111, 2'b11);
        bus1.wclken = 1'b1; bus1.waddr = 8'd9; bus1.wdata = 16'h2222; bus1.wbe = 2'b10;
        bus1.rclken = 1'b1; bus1.raddr = 8'd9;
        @(posedge clk); #1;
        check("bypass_rvalid", 32'(bus1.rvalid), 32'd1);
        check("bypass_rdata", 32'(bus1.rdata), 32'h2211);
        idle1();
        rd1(8'd9, d, v);
        check("bypass_stored", 32'(d), 32'h2211);

        // Combinational read sees the old word until the edge.
        bus0.wclken = 1'b1; bus0.waddr = 8'd3; bus0.wdata = 16'h0001; bus0.wbe = 2'b11;
        @(posedge clk); #1;
        bus0.wdata = 16'h0002; bus0.raddr = 8'd3; bus0.rclken = 1'b1;
        #1;
        check("lat0_pre_edge", 32'(bus0.rdata), 32'h0001);
        check("lat0_rvalid", 32'(bus0.rvalid), 32'd1);
        @(posedge clk); #1;
        bus0.wclken = 1'b0;
        check("lat0_post_edge", 32'(bus0.rdata), 32'h0002);
        bus0.rclken = 1'b0;
        #1;
        check("lat0_rvalid_off", 32'(bus0.rvalid), 32'd0);

        // Runtime clear over a filled array, with traffic and a repeat request.
        for (int i = 0; i < 256; i++) wr1(8'(i), 16'(i), 2'b11);
        rd1(8'd200, d, v);
        check("fill_200", 32'(d), 32'd200);
        bus1.init_req = 1'b1;
        @(posedge clk); #1;
        bus1.init_req = 1'b0;
        check("clear_busy_rise", 32'(bus1.init_busy), 32'd1);
        n = 0;
        rv_seen = 0;
        while (bus1.init_busy && n < 1000) begin
            bus1.wclken = 1'b1; bus1.waddr = 8'd7; bus1.wdata = 16'hFFFF; bus1.wbe = 2'b11;
            bus1.rclken = 1'b1; bus1.raddr = 8'd7;
            bus1.init_req = (n == 50);
            @(posedge clk); #1;
            n++;
            if (bus1.rvalid) rv_seen++;
        end
        idle1();
        check("clear_busy_len", 32'(n), 32'd256);
        check("clear_rvalid_blocked", 32'(rv_seen), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            rd1(8'(i), d, v);
            if (d !== 16'h0000 || v !== 1'b1) bad++;
        end
        check("clear_all_zero", 32'(bad), 32'd0);
        rd1(8'd7, d, v);
        check("clear_addr7", 32'(d), 32'h0000);

        // Reset in the middle of a runtime sweep restarts from address 0.
        wr1(8'd200, 16'h5A5A, 2'b11);
        rd1(8'd200, d, v);
        check("pre_rst_200", 32'(d), 32'h5A5A);
        bus1.init_req = 1'b1;
        @(posedge clk); #1;
        bus1.init_req = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 32'(bus1.rvalid), 32'd0);
        check("midrst_rdata", 32'(bus1.rdata), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        wait_idle1(n);
        check("midrst_busy_len", 32'(n), 32'd256);
        rd1(8'd200, d, v);
        check("midrst_200", 32'(d), 32'h0000);
        check("midrst_200_rvalid", 32'(v), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_mem_be.md
Name: fifo_mem_be

Overview:
- Parametrised dual-port FIFO storage array: one write port and one read port on a single clock.
- Depth is derived from the address width.
- Adds per-byte write enables and a selectable read latency of 0 or 1 cycles with write-first bypass.
- Replaces the flop-wide reset with a sequential clear engine, which can also be triggered at runtime. The FIFO write/read pointer logic sits around this block.

Parameters:
- dw, 16, data width in bits; must be a multiple of 8.
- aw, 8, address width; depth = 2**aw entries.
- rd_lat, 1, read latency: 0 = combinational read, 1 = registered read.
- nbe, dw/8, number of byte lanes (derived; not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_req  in  1  single-cycle request to clear the whole array
- init_busy  out  1  high while the clear engine is running
- wclken  in  1  write enable
- wbe  in  nbe  byte-lane write enables; bit i covers wdata[8i+7:8i]
- waddr  in  aw  write address
- wdata  in  dw  write data
- rclken  in  1  read enable
- raddr  in  aw  read address
- rdata  out  dw  read data
- rvalid  out  1  rdata is valid this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to CLEAR, clear counter goes to 0.
  - init_busy=1, rvalid=0, rdata register=0.
  - Array contents are not reset directly.
- Reset deasserted mid-operation, or asserted during CLEAR: the clear engine restarts at address 0.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to mem[cnt] (all lanes), then cnt++. When cnt==2**aw-1 is written, go to IDLE next cycle. Total 2**aw cycles in CLEAR.
  - IDLE: init_req=1 means CLEAR next cycle with cnt=0. init_busy rises the cycle after the request.
  - init_req while in CLEAR is ignored; the sweep is not restarted.
- Access during CLEAR:
  - wclken is ignored; no user write lands.
  - rclken is ignored; rvalid stays 0.
  - No backpressure signal is provided; the upstream must watch init_busy.
- Write (IDLE, wclken=1): for each i with wbe[i]=1, mem[waddr] lane i <= wdata lane i at the clock edge. Lanes with wbe[i]=0 keep their value. wclken=1 with wbe=0 changes nothing.
- Read, rd_lat=0:
  - rdata = mem[raddr] combinationally, at all times.
  - rvalid = rclken & ~init_busy.
  - A same-cycle write to the same address is visible only after the edge (read-old).
- Read, rd_lat=1:
  - On an edge with rclken=1 in IDLE, the rdata register loads mem[raddr] and rvalid=1 next cycle. Otherwise rvalid=0 and rdata holds its last value.
  - Write-first bypass: if wclken=1 and waddr==raddr in the same cycle, enabled lanes take wdata and the other lanes take the stored value.
- Address wrap: addresses are unsigned aw-bit values with no bounds check; every value is a legal entry.
- Clear counter: aw bits with an explicit terminal compare; it never rolls over into IDLE state corruption.

Decomposition:
- Package fifo_mem_pkg holds:
  - clear FSM state enum (CLEAR, IDLE);
  - function for nbe from dw;
  - lane-merge function (old, new, be) used for both writes and the bypass.
- One sub-module, fifo_mem_clr: the clear FSM plus counter. It outputs init_busy, clr_we and clr_addr, which are muxed onto the array write port.

Test Plan:
- Reset then wait: init_busy=1 for exactly 256 cycles (aw=8). Afterwards, reading addresses 0, 1, 128, 255 returns 0x0000 with rvalid one cycle after rclken (rd_lat=1).
- Byte-lane writes:
  - Write 0xABCD to addr 5 with wbe=2'b11, then 0x1234 with wbe=2'b01: reading addr 5 returns 0xAB34.
  - wbe=2'b00 write of 0xFFFF: addr 5 still reads 0xAB34.
- Write-first bypass (rd_lat=1): mem[9]=0x1111. Same cycle: wclken addr 9 data 0x2222 wbe=2'b10, rclken raddr 9. Next cycle rdata=0x2211, rvalid=1.
- rd_lat=0 same-address: mem[3]=0x0001, write 0x0002 to addr 3 with raddr=3. rdata=0x0001 before the edge and 0x0002 after.
- Runtime clear:
  - Fill addr 0..255 with the address value, then pulse init_req. init_busy=1 for 256 cycles; writes and reads issued meanwhile are dropped and rvalid=0.
  - Afterwards all addresses read 0x0000. A second init_req mid-sweep does not extend init_busy.
- Reset mid-clear: assert rst_n low at sweep cycle 100 while addr 200 holds 0x5A5A. After release, init_busy lasts a full 256 cycles and addr 200 reads 0x0000.
